// File: rtl/id_gen.sv
// Identifier stream generator: emits letters, then digits, then a space, over valid/ready.
// Optional macro ID_GEN_UPPER_EN: letters may be uppercase, selected by lfsr[5].
module id_gen #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] let_cnt,
  input  logic [LEN_W-1:0] dig_cnt,
  input  logic [7:0]       seed,
  output logic [7:0]       char,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CHAR_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_LET, S_DIG, S_SEP} state_e;

  state_e              state_q, state_d;
  logic [CHAR_W-1:0]   lfsr_q, lfsr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    dig_q, dig_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer_c;
  logic [CHAR_W-1:0]   lfsr_nxt_c;
  logic [CHAR_W-1:0]   seed_eff_c;
  logic                up_seed_c;
  logic                up_nxt_c;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [7:0] letter_of(input logic [4:0] v_in, input logic up);
    logic [4:0] v;
    v = v_in;
    if (v >= 5'd26) v = v - 5'd26;
    return (up ? 8'h41 : 8'h61) + 8'({3'b000, v});
  endfunction

  function automatic logic [7:0] digit_of(input logic [3:0] d_in);
    logic [3:0] d;
    d = d_in;
    if (d >= 4'd10) d = d - 4'd10;
    return 8'h30 + 8'({4'h0, d});
  endfunction

  assign xfer_c     = valid_q && char_ready;
  assign lfsr_nxt_c = lfsr_step(lfsr_q);
  assign seed_eff_c = (seed == 8'h00) ? 8'h01 : seed;

`ifdef ID_GEN_UPPER_EN
  assign up_seed_c = seed_eff_c[5];
  assign up_nxt_c  = lfsr_nxt_c[5];
`else
  assign up_seed_c = 1'b0;
  assign up_nxt_c  = 1'b0;
`endif

  // Outputs are computed one step ahead so the next character is ready the cycle after a transfer.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (let_cnt != '0) begin
            state_d = S_LET;
            lfsr_d  = seed_eff_c;
            cnt_d   = let_cnt;
            dig_d   = dig_cnt;
            char_d  = letter_of(seed_eff_c[4:0], up_seed_c);
            valid_d = 1'b1;
            last_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LET: begin
        if (xfer_c) begin
          lfsr_d = lfsr_nxt_c;
          if (cnt_q == LEN_W'(1)) begin
            if (dig_q != '0) begin
              state_d = S_DIG;
              cnt_d   = dig_q;
              char_d  = digit_of(lfsr_nxt_c[3:0]);
            end else begin
              state_d = S_SEP;
              char_d  = 8'h20;
              last_d  = 1'b1;
            end
          end else begin
            cnt_d  = cnt_q - LEN_W'(1);
            char_d = letter_of(lfsr_nxt_c[4:0], up_nxt_c);
          end
        end
      end
      S_DIG: begin
        if (xfer_c) begin
          lfsr_d = lfsr_nxt_c;
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_SEP;
            char_d  = 8'h20;
            last_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q - LEN_W'(1);
            char_d = digit_of(lfsr_nxt_c[3:0]);
          end
        end
      end
      S_SEP: begin
        if (xfer_c) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= 8'h01;
      cnt_q   <= '0;
      dig_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign char       = char_q;
  assign char_valid = valid_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: expected characters are queued at start and popped on each transfer.
module tb_id_gen;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] let_cnt = '0;
  logic [LEN_W-1:0] dig_cnt = '0;
  logic [7:0]       seed = 8'h00;
  logic             char_ready = 1'b1;
  logic [7:0]       char;
  logic             char_valid;
  logic             last;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  id_gen #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .let_cnt(let_cnt), .dig_cnt(dig_cnt),
    .seed(seed), .char(char), .char_valid(char_valid), .char_ready(char_ready),
    .last(last), .busy(busy), .done(done), .err(err)
  );

  int         n_vec = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  bit         rand_ready = 1'b0;
  bit         stall_prev = 1'b0;
  bit         done_pend = 1'b0;
  bit         done_seen = 1'b0;
  bit         err_exp = 1'b0;
  logic [7:0] prev_char = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] m_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic logic [7:0] m_letter(input logic [7:0] s);
    int v;
    v = int'(s[4:0]) % 26;
`ifdef ID_GEN_UPPER_EN
    if (s[5]) return 8'(65 + v);
`endif
    return 8'(97 + v);
  endfunction

  function automatic logic [7:0] m_digit(input logic [7:0] s);
    return 8'(48 + int'(s[3:0]) % 10);
  endfunction

  task automatic push_model(input logic [7:0] sd, input int nl, input int nd);
    logic [7:0] s;
    s = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < nl; i++) begin
      exp_q.push_back({1'b0, m_letter(s)});
      s = m_next(s);
    end
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back({1'b0, m_digit(s)});
      s = m_next(s);
    end
    exp_q.push_back({1'b1, 8'h20});
  endtask

  task automatic monitor();
    logic [8:0] e;
    bit         pend_next;
    pend_next = 1'b0;
    chk("done", 32'(done), 32'(done_pend));
    if (done_pend) chk("busy_after_done", 32'(busy), 0);
    if (done) done_seen = 1'b1;
    chk("err", 32'(err), 32'(err_exp));
    if (stall_prev) begin
      chk("stall_valid", 32'(char_valid), 1);
      chk("stall_char", 32'(char), 32'(prev_char));
      chk("stall_last", 32'(last), 32'(prev_last));
    end
    if (char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_char", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk("char", 32'(char), 32'(e[7:0]));
        chk("last", 32'(last), 32'(e[8]));
      end
      if (last) pend_next = 1'b1;
    end
    stall_prev = char_valid && !char_ready;
    prev_char  = char;
    prev_last  = last;
    done_pend  = pend_next;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor();
    @(posedge clk);
    #1;
    if (rand_ready) char_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_id(input logic [7:0] sd, input int nl, input int nd, input bit use_model);
    seed    = sd;
    let_cnt = LEN_W'(nl);
    dig_cnt = LEN_W'(nd);
    start   = 1'b1;
    if (use_model) push_model(sd, nl, nd);
    done_seen = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_on", 32'(busy), 1);
    chk("valid_on", 32'(char_valid), 1);
  endtask

  task automatic wait_done(input int exp_cycles, input bit pulse_busy);
    int k;
    for (k = 1; k <= 300; k++) begin
      if (pulse_busy && k == 2) begin
        chk("busy_mid", 32'(busy), 1);
        start = 1'b1; let_cnt = '0; seed = 8'hAA;
      end
      if (pulse_busy && k == 3) start = 1'b0;
      tick();
      if (done_seen) break;
    end
    chk("done_timeout", 32'(done_seen), 1);
    if (exp_cycles >= 0) chk("latency", 32'(k), 32'(exp_cycles));
    tick();
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_char", 32'(char), 0);
    chk("rst_valid", 32'(char_valid), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    // seed 01, one letter, one digit
    exp_q.push_back({1'b0, 8'h62});
    exp_q.push_back({1'b0, 8'h32});
    exp_q.push_back({1'b1, 8'h20});
    start_id(8'h01, 1, 1, 1'b0);
    wait_done(4, 1'b0);

    // zero seed is remapped to 01
    exp_q.push_back({1'b0, 8'h62});
    exp_q.push_back({1'b0, 8'h32});
    exp_q.push_back({1'b1, 8'h20});
    start_id(8'h00, 1, 1, 1'b0);
    wait_done(4, 1'b0);

    // no digits: separator follows the letter directly
`ifdef ID_GEN_UPPER_EN
    exp_q.push_back({1'b0, 8'h46});
`else
    exp_q.push_back({1'b0, 8'h66});
`endif
    exp_q.push_back({1'b1, 8'h20});
    start_id(8'h3F, 1, 0, 1'b0);
    wait_done(3, 1'b0);

    // rejected start
    let_cnt = '0; dig_cnt = LEN_W'(3); seed = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_no_valid", 32'(char_valid), 0);
    chk("err_no_busy", 32'(busy), 0);
    err_exp = 1'b1;
    tick();
    err_exp = 1'b0;
    tick();
    chk("err_no_valid2", 32'(char_valid), 0);

    // max counts with ready held
    start_id(8'h9D, 15, 15, 1'b1);
    wait_done(32, 1'b0);

    // random back-pressure plus ignored starts while busy
    rand_ready = 1'b1;
    start_id(8'h01, 3, 2, 1'b1);
    wait_done(-1, 1'b1);
    start_id(8'hC5, 15, 7, 1'b1);
    wait_done(-1, 1'b1);
    rand_ready = 1'b0;
    char_ready = 1'b1;
    tick();

    // async reset in the digit phase, then a full restart
    start_id(8'h01, 3, 8, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(char_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_last", 32'(last), 0);
    chk("mid_rst_char", 32'(char), 0);
    exp_q.delete();
    stall_prev = 1'b0;
    done_pend  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_id(8'h01, 3, 8, 1'b1);
    wait_done(13, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/id_gen.md
# id_gen

Identifier stream generator: on request, emits one identifier (a run of letters followed by a run of digits) as an 8-bit ASCII character stream, terminated by a space separator. The letters come first so the stream matches the letters-then-digits pattern the identifier recognizer detects. Characters are pseudo-random from an internal 8-bit LFSR. The block sits in front of the recognizer FSM as its stimulus/transmit end, delivering characters over a valid/ready handshake.

## Interface
- LEN_W, 4, width of the letter and digit count inputs
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- let_cnt  in  LEN_W  number of letters (1..2^LEN_W-1)
- dig_cnt  in  LEN_W  number of digits (0..2^LEN_W-1)
- seed  in  8  LFSR seed loaded on accepted start
- char  out  8  ASCII character
- char_valid  out  1  char is valid
- char_ready  in  1  sink accepts char this cycle
- last  out  1  high with the separator character
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after separator handshake
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, LET, DIG, SEP.
- IDLE + start + let_cnt!=0: latch counts; load lfsr = (seed==0) ? 8'h01 : seed; go to LET; busy=1.
- IDLE + start + let_cnt==0: stay IDLE; pulse err next cycle; no characters emitted.
- start outside IDLE is ignored (no err).
- Handshake: a transfer occurs on a cycle with char_valid && char_ready. While char_valid && !char_ready, char and last hold stable. char_valid never drops without a transfer.
- LFSR: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Advances only on a transfer in LET or DIG.
- Letter (LET): v = lfsr[4:0]; if v>=26 then v = v-26. char = 8'h61 + v (lowercase); case selection is covered under Configuration.
- Digit (DIG): d = lfsr[3:0]; if d>=10 then d = d-10. char = 8'h30 + d.
- LET: after let_cnt transfers, go to DIG if dig_cnt!=0, otherwise go to SEP.
- DIG: after dig_cnt transfers, go to SEP.
- SEP: char = 8'h20, last=1. On transfer: go to IDLE; busy=0; done=1 for one cycle.
- Counter arithmetic is unsigned LEN_W bits. Down-counters are loaded from the latched counts, so they never wrap.

## Timing
- Reset values: state IDLE, char 8'h00, char_valid 0, last 0, busy 0, done 0, err 0, lfsr 8'h01.
- Asynchronous reset is effective mid-stream: all outputs return to their reset values immediately, and the partial identifier is abandoned.
- char, char_valid, last, busy, done and err are all registered.
- start is accepted at edge N. The first char_valid=1 appears after edge N, i.e. in cycle N+1.
- With char_ready held at 1, throughput is one character per cycle. The transfer that exits LET or DIG is followed in the next cycle by the first character of the next phase, with no bubble.
- A separator transferred at edge M gives done=1 and busy=0 in cycle M+1. A new start is accepted no earlier than edge M+1.
- The cycle-by-cycle character content depends only on seed, the counts and the number of transfers. It does not depend on stall timing.

## Configuration
- ID_GEN_UPPER_EN defined: in LET, lfsr[5]=1 selects uppercase (char = 8'h41 + v); lfsr[5]=0 selects lowercase.
- ID_GEN_UPPER_EN undefined: letters are always lowercase. All other behaviour is identical.

## Test plan
- seed=8'h01, let=1, dig=1, ready=1 -> chars 8'h62 ('b'), 8'h32 ('2'), 8'h20 with last=1. done pulses in the cycle after the separator.
- seed=8'h00, let=1, dig=1 -> identical stream to seed=8'h01 (zero seed is remapped to 8'h01).
- seed=8'h3F, let=1, dig=0 -> first char 8'h46 ('F') with ID_GEN_UPPER_EN, 8'h66 ('f') without; then the separator immediately.
- let=0, dig=3, start -> err=1 for one cycle, char_valid stays 0, busy stays 0.
- seed=8'h01, let=3, dig=2, char_ready toggling randomly:
  - The byte sequence equals the ready=1 run.
  - char and last are stable during every stall.
  - start pulses while busy are ignored.
- Assert rst_n low in mid-DIG -> char_valid, busy and last drop at once, lfsr returns to 8'h01. A following start emits the full stream from the beginning.
